// File: rtl/mips_instr_fetch.sv
// mips_instr_fetch: PC, fetch/decode register, delay-slot redirects and halt; FETCH_ALIGN_CHECK_EN adds fetch_fault
module mips_instr_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        active
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);
  typedef enum logic {FETCH, HALTED} state_t;
  state_t state, state_nx;
  logic [31:0] pc, pc_nx, pending_target, tgt;
  logic pending_valid, use_tgt, stop, issue;
  assign instr_address = pc;
  assign use_tgt = redirect_valid || pending_valid;
  assign tgt = redirect_valid ? redirect_target : pending_target;
  assign pc_nx = use_tgt ? tgt & ~32'h3 : pc + 32'd4;
`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign;
  assign stop = state == FETCH && !stall && (pc == HALT_ADDR || misalign);
  // the aligned target reaches pc, but the fault halts before it is ever issued
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      misalign <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      if (issue) misalign <= use_tgt && tgt[1:0] != 2'b00;
      if (stop && misalign) fetch_fault <= 1'b1;
    end
`else
  assign stop = state == FETCH && !stall && pc == HALT_ADDR;
`endif
  assign issue = state == FETCH && !stall && !stop;
  always_comb state_nx = stop ? HALTED : state;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= FETCH;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc <= RESET_VECTOR;
      instr_out <= 32'd0;
      instr_pc <= 32'd0;
      instr_valid <= 1'b0;
      active <= 1'b1;
      pending_valid <= 1'b0;
      pending_target <= 32'd0;
    end else if (issue) begin
      instr_out <= instr_readdata;
      instr_pc <= pc;
      instr_valid <= 1'b1;
      pc <= pc_nx;
      pending_valid <= 1'b0;
    end else if (stop) begin
      instr_valid <= 1'b0;
      active <= 1'b0;
    end else if (state == FETCH && redirect_valid) begin
      pending_valid <= 1'b1;
      pending_target <= redirect_target;
    end
endmodule

// File: tb/tb_mips_instr_fetch.sv
// tb_mips_instr_fetch: directed vector table, corner sequences and randomized run against a reference model
module tb_mips_instr_fetch;
  logic clk = 1'b0, reset = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic [31:0] instr_address, instr_readdata, instr_out, instr_pc;
  logic instr_valid, active;
`ifdef FETCH_ALIGN_CHECK_EN
  logic fetch_fault;
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  int checks = 0, errors = 0;
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction
  assign instr_readdata = mem(instr_address);
  always #5 clk = ~clk;
  mips_instr_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .instr_address(instr_address),
    .instr_readdata(instr_readdata), .instr_out(instr_out), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .active(active)
`ifdef FETCH_ALIGN_CHECK_EN
    , .fetch_fault(fetch_fault)
`endif
  );
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic do_reset;
    reset = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask
  // reference model: what decode should observe, following the fetch rules directly
  logic [31:0] m_pc, m_opc, m_out, m_pt;
  bit m_valid, m_active, m_pend, m_mis, m_fault;
  task automatic m_init;
    m_pc = 32'hBFC00000; m_opc = 0; m_out = 0; m_pt = 0;
    m_valid = 0; m_active = 1; m_pend = 0; m_mis = 0; m_fault = 0;
  endtask
  task automatic m_step(input bit st, input bit rv, input logic [31:0] rt);
    logic [31:0] t;
    bit ut;
    if (!m_active) return;
    if (st) begin
      if (rv) begin m_pend = 1; m_pt = rt; end
      return;
    end
    if (m_pc == 32'd0 || m_mis) begin
      m_valid = 0; m_active = 0;
      if (m_mis) m_fault = 1;
      return;
    end
    m_opc = m_pc; m_out = mem(m_pc); m_valid = 1;
    ut = rv || m_pend;
    t = rv ? rt : m_pt;
    m_pend = 0;
    m_mis = ALIGN && ut && t[1:0] != 2'b00;
    m_pc = ut ? {t[31:2], 2'b00} : m_pc + 32'd4;
  endtask
  typedef struct {
    bit st;
    bit rv;
    logic [31:0] rt;
    logic [31:0] e_pc;
    logic [31:0] e_addr;
    bit e_valid;
    bit e_active;
  } vec_t;
  vec_t tbl[14];
  initial begin
    bit st, rv;
    logic [31:0] rt;
    tbl[0]  = '{0, 0, 32'h0,        32'hBFC00000, 32'hBFC00004, 1, 1};
    tbl[1]  = '{0, 0, 32'h0,        32'hBFC00004, 32'hBFC00008, 1, 1};
    tbl[2]  = '{0, 1, 32'hBFC00100, 32'hBFC00008, 32'hBFC00100, 1, 1};
    tbl[3]  = '{0, 0, 32'h0,        32'hBFC00100, 32'hBFC00104, 1, 1};
    tbl[4]  = '{0, 0, 32'h0,        32'hBFC00104, 32'hBFC00108, 1, 1};
    tbl[5]  = '{1, 0, 32'h0,        32'hBFC00104, 32'hBFC00108, 1, 1};
    tbl[6]  = '{1, 1, 32'hBFC00200, 32'hBFC00104, 32'hBFC00108, 1, 1};
    tbl[7]  = '{1, 0, 32'h0,        32'hBFC00104, 32'hBFC00108, 1, 1};
    tbl[8]  = '{0, 0, 32'h0,        32'hBFC00108, 32'hBFC00200, 1, 1};
    tbl[9]  = '{0, 0, 32'h0,        32'hBFC00200, 32'hBFC00204, 1, 1};
    tbl[10] = '{0, 1, 32'h0,        32'hBFC00204, 32'h00000000, 1, 1};
    tbl[11] = '{0, 0, 32'h0,        32'hBFC00204, 32'h00000000, 0, 0};
    tbl[12] = '{0, 1, 32'hBFC00000, 32'hBFC00204, 32'h00000000, 0, 0};
    tbl[13] = '{1, 0, 32'h0,        32'hBFC00204, 32'h00000000, 0, 0};
    do_reset;
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_active", {31'd0, active}, 32'd1);
    chk("rst_addr", instr_address, 32'hBFC00000);
    chk("rst_out", instr_out, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    for (int i = 0; i < 14; i++) begin
      stall = tbl[i].st;
      redirect_valid = tbl[i].rv;
      redirect_target = tbl[i].rt;
      @(posedge clk); #1;
      chk($sformatf("v%0d_pc", i), instr_pc, tbl[i].e_pc);
      chk($sformatf("v%0d_out", i), instr_out, mem(tbl[i].e_pc));
      chk($sformatf("v%0d_addr", i), instr_address, tbl[i].e_addr);
      chk($sformatf("v%0d_valid", i), {31'd0, instr_valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("v%0d_active", i), {31'd0, active}, {31'd0, tbl[i].e_active});
    end
    stall = 0; redirect_valid = 0;
    do_reset;
    @(posedge clk); #1;
    @(posedge clk); #3;
    chk("mid_pre_pc", instr_pc, 32'hBFC00004);
    reset = 1'b0;
    #1;
    chk("mid_valid", {31'd0, instr_valid}, 32'd0);
    chk("mid_addr", instr_address, 32'hBFC00000);
    chk("mid_active", {31'd0, active}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_resume_pc", instr_pc, 32'hBFC00000);
    chk("mid_resume_valid", {31'd0, instr_valid}, 32'd1);
    do_reset;
    @(posedge clk); #1;
    redirect_valid = 1; redirect_target = 32'hBFC00102;
    @(posedge clk); #1;
    redirect_valid = 0;
    chk("mis_slot_pc", instr_pc, 32'hBFC00004);
    chk("mis_slot_valid", {31'd0, instr_valid}, 32'd1);
    chk("mis_addr_lsb", {30'd0, instr_address[1:0]}, 32'd0);
    @(posedge clk); #1;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
    chk("mis_active", {31'd0, active}, 32'd0);
    chk("mis_valid", {31'd0, instr_valid}, 32'd0);
    @(posedge clk); #1;
    chk("mis_frozen_addr_lsb", {30'd0, instr_address[1:0]}, 32'd0);
    chk("mis_frozen_pc", instr_pc, 32'hBFC00004);
`else
    chk("mis_tgt_pc", instr_pc, 32'hBFC00100);
    chk("mis_tgt_valid", {31'd0, instr_valid}, 32'd1);
    @(posedge clk); #1;
    chk("mis_tgt_next_pc", instr_pc, 32'hBFC00104);
`endif
    for (int r = 0; r < 4; r++) begin
      do_reset;
      m_init;
      for (int c = 0; c < 250; c++) begin
        st = $urandom_range(3) == 0;
        rv = m_valid && $urandom_range(5) == 0;
        rt = {16'hBFC0, 14'($urandom), 2'b00};
        if ($urandom_range(29) == 0) rt = 32'd0;
        else if ($urandom_range(9) == 0) rt[1:0] = 2'($urandom_range(1, 3));
        stall = st; redirect_valid = rv; redirect_target = rt;
        @(posedge clk);
        m_step(st, rv, rt);
        #1;
        chk("rnd_addr", instr_address, m_pc);
        chk("rnd_pc", instr_pc, m_opc);
        chk("rnd_out", instr_out, m_out);
        chk("rnd_valid", {31'd0, instr_valid}, {31'd0, m_valid});
        chk("rnd_active", {31'd0, active}, {31'd0, m_active});
`ifdef FETCH_ALIGN_CHECK_EN
        chk("rnd_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
`endif
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_instr_fetch.md
Name: mips_instr_fetch

Overview:
- Instruction-fetch initiator for the MIPS CPU; drives the instruction-memory port and receives the instruction word back.
- Owns the PC and registers each fetched word into a fetch/decode register.
- Handles decode stalls, branch/jump redirects with the MIPS single delay slot, and halt on fetch from HALT_ADDR.
- Sits between instruction memory (zero-latency combinational read) and the decode stage.

Parameters:
- RESET_VECTOR, 32'hBFC00000: PC value loaded on reset.
- HALT_ADDR, 32'h00000000: a fetch attempt at this PC halts the CPU.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  decode not ready; hold fetch/decode register and PC.
- redirect_valid  in  1  branch/jump taken by the instruction currently on instr_out.
- redirect_target  in  32  byte address of the branch/jump target.
- instr_address  out  32  byte address to instruction memory; always word-aligned.
- instr_readdata  in  32  word returned by instruction memory, same cycle.
- instr_out  out  32  registered instruction to decode.
- instr_pc  out  32  PC of instr_out.
- instr_valid  out  1  instr_out holds a live instruction.
- active  out  1  high while CPU runs; low once halted.

Behaviour:
- Reset (reset=0, asynchronous, immediate): pc=RESET_VECTOR, instr_out=0, instr_pc=0, instr_valid=0, active=1, pending_valid=0, pending_target=0, state=FETCH.
- instr_address = pc, combinational; pc[1:0] always 0. Targets are loaded with bits [1:0] forced to 0.
- State FETCH, stall=0, pc!=HALT_ADDR: at the clock edge, instr_out<=instr_readdata, instr_pc<=pc, instr_valid<=1, pc<=next_pc.
- next_pc priority, highest first:
  - redirect_valid=1: redirect_target.
  - pending_valid=1: pending_target, and pending_valid clears.
  - Otherwise: pc+4, wrapping mod 2^32.
- Delay slot: redirect_valid arrives while the branch sits on instr_out. pc then already holds branch+4, which is issued that cycle. The target follows next. Exactly one delay-slot instruction is always issued.
- State FETCH, stall=1: pc, instr_out, instr_pc and instr_valid are held. If redirect_valid=1, pending_valid<=1 and pending_target<=redirect_target. A later redirect overwrites pending_target.
- Halt: in FETCH with stall=0 and pc==HALT_ADDR, no instruction is issued. instr_valid<=0, active<=0, state<=HALTED.
- Halt while stall=1: deferred until stall=0.
- State HALTED: all registers frozen, instr_valid=0, active=0. stall and redirect_valid are ignored. Only reset exits.
- Decode drives redirect_valid only when instr_valid=1. The block does not check this; otherwise behaviour is undefined.

Optional Feature:
- Macro FETCH_ALIGN_CHECK_EN.
- Defined:
  - Adds output fetch_fault (1 bit), reset value 0.
  - A redirect (direct or pending) with target[1:0]!=0 sets fetch_fault=1, which is sticky until reset.
  - instr_valid<=0, active<=0, state<=HALTED; the misaligned target is never fetched.
- Undefined: no fetch_fault port; target[1:0] is silently cleared and fetch continues.

Test Plan:
- Reset release, stall=0, no redirects → instr_address BFC00000, BFC00004, BFC00008 on consecutive cycles. instr_valid=1 from first edge with instr_pc=BFC00000; instr_out equals memory word at each address.
- Branch at BFC00004 on instr_out, redirect_valid=1, target BFC00100 → next instr_pc BFC00008 (delay slot), then BFC00100, BFC00104.
- Branch on instr_out with stall=1 for 3 cycles; redirect_valid pulsed in stall cycle 2 with target BFC00200 → outputs frozen 3 cycles; after release instr_pc = branch+4, then BFC00200.
- Redirect to 00000000 → delay slot issued, then the next edge gives active=0 and instr_valid=0. Later redirect_valid=1 to BFC00000 leaves pc and active unchanged.
- reset=0 asserted mid-stream between edges → immediately instr_valid=0, instr_address=BFC00000, active=1. Fetch resumes at BFC00000 after release.
- With FETCH_ALIGN_CHECK_EN, redirect target BFC00102 → delay slot issued; next edge fetch_fault=1, active=0, instr_valid=0; address BFC00102 never driven. Without the macro, fetch proceeds from BFC00100.
